// File: rtl/circuit_test_sequencer_pkg.sv
// Shared types and constants for the circuit test sequencer.
// Holds the run FSM state encoding, vector geometry and a popcount helper.
package circuit_test_sequencer_pkg;

  localparam int NUM_VECTORS  = 4;
  localparam int DUT_IN_WIDTH = 2;

  // ST_NEXT is folded into the last SAMPLE cycle and never occupies a cycle.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_NEXT,
    ST_DONE
  } state_t;

  function automatic logic [2:0] popcount4(input logic [NUM_VECTORS-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/circuit_test_sequencer_sample_checker.sv
// Per-vector sample window: captures the reference sample and flags any later disagreement.
// Outputs include the current-cycle sample so the final verdict is ready on the last sample cycle.
module sample_checker #(
  parameter int SAMPLE_COUNT = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic sample_en_i,
  input  logic bit_i,
  output logic last_o,
  output logic ref_o,
  output logic unstable_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       ref_q, ref_d;
  logic       flag_q, flag_d;
  logic       first;

  assign first = (cnt_q == 8'd0);

  always_comb begin
    cnt_d  = cnt_q;
    ref_d  = ref_q;
    flag_d = flag_q;
    if (clear_i) begin
      cnt_d  = '0;
      ref_d  = 1'b0;
      flag_d = 1'b0;
    end else if (sample_en_i) begin
      cnt_d = cnt_q + 8'd1;
      if (first) begin
        ref_d = bit_i;
      end else if (bit_i != ref_q) begin
        flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      ref_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ref_q  <= ref_d;
      flag_q <= flag_d;
    end
  end

  assign last_o     = sample_en_i && (cnt_q == 8'(SAMPLE_COUNT - 1));
  assign ref_o      = first ? bit_i : ref_q;
  assign unstable_o = flag_q | (!first && (bit_i != ref_q));

endmodule

// File: rtl/circuit_test_sequencer.sv
// Applies all four 2-bit vectors to an evolved circuit, settles, samples and scores the response.
// Optional CTS_INPUT_SYNC_EN adds a two-flop synchronizer on dut_out and two extra settle cycles.
module circuit_test_sequencer
  import circuit_test_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_COUNT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_VECTORS-1:0]  expected,
  output logic [DUT_IN_WIDTH-1:0] dut_in,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_VECTORS-1:0]  pass_vec,
  output logic [NUM_VECTORS-1:0]  unstable_vec,
  output logic [2:0]              score
);

  logic sample_bit;

`ifdef CTS_INPUT_SYNC_EN
  localparam int SETTLE_TOTAL = SETTLE_CYCLES + 2;
  logic sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= dut_out;
      sync2_q <= sync1_q;
    end
  end
  assign sample_bit = sync2_q;
`else
  localparam int SETTLE_TOTAL = SETTLE_CYCLES;
  assign sample_bit = dut_out;
`endif

  state_t                    state_q;
  logic [DUT_IN_WIDTH-1:0]   vec_q;
  logic [DUT_IN_WIDTH-1:0]   dut_in_q;
  logic [8:0]                settle_q;
  logic [NUM_VECTORS-1:0]    exp_q, pass_q, unst_q;
  logic [NUM_VECTORS-1:0]    pass_d, unst_d;
  logic [2:0]                score_q;
  logic                      done_q;
  logic                      chk_last, chk_ref, chk_unstable;

  sample_checker #(.SAMPLE_COUNT(SAMPLE_COUNT)) u_checker (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (state_q == ST_APPLY),
    .sample_en_i (state_q == ST_SAMPLE),
    .bit_i       (sample_bit),
    .last_o      (chk_last),
    .ref_o       (chk_ref),
    .unstable_o  (chk_unstable)
  );

  always_comb begin
    pass_d        = pass_q;
    unst_d        = unst_q;
    pass_d[vec_q] = !chk_unstable && (chk_ref == exp_q[vec_q]);
    unst_d[vec_q] = chk_unstable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      dut_in_q <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      pass_q   <= '0;
      unst_q   <= '0;
      score_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        // Partial results are deliberately left in place.
        state_q  <= ST_IDLE;
        dut_in_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start) begin
              exp_q    <= expected;
              pass_q   <= '0;
              unst_q   <= '0;
              score_q  <= '0;
              vec_q    <= '0;
              dut_in_q <= '0;
              state_q  <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            settle_q <= '0;
            state_q  <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settle_q == 9'(SETTLE_TOTAL - 1)) begin
              state_q <= ST_SAMPLE;
            end else begin
              settle_q <= settle_q + 9'd1;
            end
          end
          ST_SAMPLE: begin
            if (chk_last) begin
              pass_q <= pass_d;
              unst_q <= unst_d;
              if (vec_q == DUT_IN_WIDTH'(NUM_VECTORS - 1)) begin
                score_q  <= popcount4(pass_d);
                done_q   <= 1'b1;
                dut_in_q <= '0;
                state_q  <= ST_DONE;
              end else begin
                vec_q    <= vec_q + 1'b1;
                dut_in_q <= vec_q + 1'b1;
                state_q  <= ST_APPLY;
              end
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign pass_vec     = pass_q;
  assign unstable_vec = unst_q;
  assign score        = score_q;

endmodule

// File: tb/tb_circuit_test_sequencer.sv
// Scoreboarded bench: a behavioural evolved-circuit model drives dut_out, runs push expected results.
// A negedge monitor pops and checks results and timing on every done pulse.
module tb_circuit_test_sequencer;

  localparam int S = 16;
  localparam int N = 8;
`ifdef CTS_INPUT_SYNC_EN
  localparam int LAT = 4 * (3 + S + N) + 1;
`else
  localparam int LAT = 4 * (1 + S + N) + 1;
`endif

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] expected;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done;
  logic [3:0] pass_vec, unstable_vec;
  logic [2:0] score;

  circuit_test_sequencer #(.SETTLE_CYCLES(S), .SAMPLE_COUNT(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .expected     (expected),
    .dut_in       (dut_in),
    .dut_out      (dut_out),
    .busy         (busy),
    .done         (done),
    .pass_vec     (pass_vec),
    .unstable_vec (unstable_vec),
    .score        (score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Evolved circuit: truth table tt, except vectors flagged noisy toggle every cycle.
  logic [3:0] tt = 4'b0000;
  logic [3:0] noisy = 4'b0000;
  logic       tog = 1'b0;
  always @(negedge clk) tog = ~tog;
  assign dut_out = noisy[dut_in] ? tog : tt[dut_in];

  typedef struct {
    logic [3:0] pass;
    logic [3:0] unst;
    logic [2:0] score;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int nchk = 0;
  int nfail = 0;
  logic [3:0] last_p, last_u;

  task automatic check(input string name, input int act, input int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        nchk++;
        nfail++;
        $display("FAIL unexpected_done: got done=1 want none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("pass_vec", int'(pass_vec), int'(e.pass));
        check("unstable_vec", int'(unstable_vec), int'(e.unst));
        check("score", int'(score), int'(e.score));
      end
    end
  end

  // Reference: a vector passes when its output is steady and equals the expectation.
  task automatic model(input logic [3:0] t, input logic [3:0] nz, input logic [3:0] ex,
                       output logic [3:0] p, output logic [3:0] u);
    u = nz;
    p = ~nz & ~(t ^ ex);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [3:0] t, input logic [3:0] nz, input logic [3:0] ex,
                           input bit expect_done);
    logic [3:0] p, u;
    exp_t x;
    tt       = t;
    noisy    = nz;
    expected = ex;
    model(t, nz, ex, p, u);
    last_p = p;
    last_u = u;
    if (expect_done) begin
      x.pass  = p;
      x.unst  = u;
      x.score = 3'($countones(p));
      x.cyc   = cyc + LAT;
      sb.push_back(x);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (sb.size() != 0 || busy); i++) step(1);
    check("drain_pending", sb.size(), 0);
    check("idle_after_run", int'(busy), 0);
  endtask

  // Full run with a stray start at offset 55 and expectation churn mid-run.
  task automatic full_run(input logic [3:0] t, input logic [3:0] nz, input logic [3:0] ex);
    start_run(t, nz, ex, 1'b1);
    for (int off = 1; off < LAT + 3; off++) begin
      start = (off == 55);
      if ($urandom_range(0, 5) == 0) expected = 4'($urandom);
      step(1);
    end
    start = 1'b0;
    wait_idle();
    step(3);
    check("hold_pass", int'(pass_vec), int'(last_p));
    check("hold_unstable", int'(unstable_vec), int'(last_u));
    check("hold_score", int'(score), $countones(last_p));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; expected = 4'b0000;
    step(3);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dut_in", int'(dut_in), 0);
    check("rst_pass", int'(pass_vec), 0);
    check("rst_unstable", int'(unstable_vec), 0);
    check("rst_score", int'(score), 0);
    rst = 1'b0;
    step(2);

    full_run(4'b0110, 4'b0000, 4'b0110);
    full_run(4'b0000, 4'b0000, 4'b0110);
    full_run(4'b1000, 4'b0100, 4'b1000);

    // start with abort in IDLE must not launch a run.
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", int'(busy), 0);
    step(2);

    // Abort at offset 40, then restart at offset 50.
    start_run(4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
    step(39);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_dut_in", int'(dut_in), 0);
    check("abort_pass", int'(pass_vec), int'({3'b000, last_p[0]}));
    check("abort_unstable", int'(unstable_vec), int'({3'b000, last_u[0]}));
    check("abort_score", int'(score), 0);
    step(9);
    check("pre_restart_idle", int'(busy), 0);
    full_run(4'($urandom), 4'($urandom), 4'($urandom));

    // Reset mid-run: stray start at 55 then reset at 60.
    start_run(4'($urandom), 4'b0000, 4'($urandom), 1'b0);
    step(54);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_dut_in", int'(dut_in), 0);
    check("mid_rst_pass", int'(pass_vec), 0);
    check("mid_rst_unstable", int'(unstable_vec), 0);
    check("mid_rst_score", int'(score), 0);
    step(5);

    for (int r = 0; r < 8; r++) begin
      full_run(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, 4'($urandom));
    end

    step(5);
    check("final_queue", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/circuit_test_sequencer.md
CIRCUIT_TEST_SEQUENCER -- requirements
Module: circuit_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: idle cycles after driving a vector before sampling (range 1..255).
REQ-002 SHALL have parameter SAMPLE_COUNT, default 8: consecutive samples of dut_out per vector (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: begin a test run; honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancel the current run.
REQ-007 SHALL have port expected, input, 4 bits: truth table; bit v is the required output for input vector v.
REQ-008 SHALL have port dut_in, output, 2 bits: vector applied to the evolved circuit under test.
REQ-009 SHALL have port dut_out, input, 1 bit: asynchronous output of the evolved circuit.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-012 SHALL have port pass_vec, output, 4 bits: bit v set when vector v was stable and matched expected[v].
REQ-013 SHALL have port unstable_vec, output, 4 bits: bit v set when the samples for vector v disagreed.
REQ-014 SHALL have port score, output, 3 bits: popcount of pass_vec (0..4).

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, SETTLE, SAMPLE, NEXT, DONE.
REQ-016 IDLE with start=1 SHALL latch expected, clear pass_vec/unstable_vec/score, set vector index v=0 and go to APPLY.
REQ-017 APPLY SHALL drive dut_in=v for one cycle, then go to SETTLE; dut_in SHALL hold v until the next APPLY or until returning to IDLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL last exactly SAMPLE_COUNT cycles: the first sample is the reference value; any later sample differing from it sets unstable for vector v.
REQ-020 NEXT SHALL write pass_vec[v] = (not unstable) and (reference == latched expected[v]), then go to APPLY with v+1 if v<3, else to DONE; NEXT SHALL add no cycle of its own (it is evaluated on the last SAMPLE cycle).
REQ-021 DONE SHALL assert done for one cycle, update score, drive dut_in=0 and return to IDLE.
REQ-022 Run latency from the cycle start is accepted to the done pulse SHALL be 4*(1+SETTLE_CYCLES+SAMPLE_COUNT)+1 cycles (101 with defaults, sync disabled).
REQ-023 start while busy SHALL be ignored; changes to expected during a run SHALL have no effect.
REQ-024 abort SHALL take priority over start and over every transition, go to IDLE next cycle, drive dut_in=0, produce no done, and leave pass_vec/unstable_vec/score holding the partial values already written.
REQ-025 Results SHALL hold stable from done until the next accepted start.
REQ-026 start and abort asserted in the same IDLE cycle SHALL leave the block in IDLE.

Reset
REQ-027 While rst=1 the block SHALL enter IDLE with dut_in=0, busy=0, done=0, pass_vec=0, unstable_vec=0, score=0, and all counters=0.
REQ-028 rst asserted mid-run SHALL discard the run with no done pulse; rst SHALL override abort and start.

Configuration
REQ-029 Macro CTS_INPUT_SYNC_EN defined: dut_out SHALL pass through a two-flop synchronizer before sampling, and SETTLE SHALL be extended by 2 cycles, so run latency is 4*(3+SETTLE_CYCLES+SAMPLE_COUNT)+1.
REQ-030 Macro undefined: dut_out SHALL be sampled directly, with latency per REQ-022.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, NUM_VECTORS=4, and DUT_IN_WIDTH=2.
REQ-032 Sub-module sample_checker SHALL hold the sample counter, reference bit, and disagreement flag, cleared at each APPLY.

Verification
REQ-033 Ideal XOR model, expected=4'b0110, start -> done at cycle 101, pass_vec=4'b1111, unstable_vec=0, score=4.
REQ-034 Output stuck at 0, expected=4'b0110 -> pass_vec=4'b1001, score=2, unstable_vec=0.
REQ-035 Output toggling every cycle while dut_in=2, AND elsewhere, expected=4'b1000 -> unstable_vec=4'b0100, pass_vec=4'b1011, score=3.
REQ-036 abort at cycle 40 -> IDLE at cycle 41, no done, dut_in=0, pass_vec bit 0 retained; a start issued at cycle 50 during the aborted run's former timing is accepted.
REQ-037 rst pulsed at cycle 60 of a run -> all outputs 0 next cycle, no done; start at cycle 55 while busy is ignored.
REQ-038 With CTS_INPUT_SYNC_EN defined, scenario REQ-033 -> done at cycle 109 with identical results.
